column_end_readout: RTL and testbench

Column-end receiver for the super-pixel arbiter chain. Sits at the top of one super-pixel column and accepts 26-bit `arbiter_data` words that the chain pushes toward the column end. It acknowledges each word over the `shake_hands` line and buffers the words in a small FIFO. Each word is tagged with the column address and offered to the chip-level readout with a valid/ready handshake.

---
 rtl/pixel_rout_pkg.sv | 27 ++
 rtl/rout_sync_fifo.sv | 74 +++++++
 rtl/column_end_readout.sv | 118 +++++++++++
 tb/tb_column_end_readout.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_rout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_rout_pkg
//  Description : Shared constants and capture-FSM encoding for the
//                super-pixel column-end readout.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_rout_pkg;

    // Arbiter word width and the index of its hit-valid flag
    localparam int ARB_DATA_W    = 26;
    localparam int ARB_VALID_BIT = 25;

    // Default column-address tag width
    localparam int COL_ADDR_W_DEF = 5;

    // Accepted-word counter width
    localparam int HIT_CNT_W = 16;

    // Capture FSM: IDLE offers the handshake, ACK withholds it for one cycle
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_e;

endpackage : pixel_rout_pkg
`default_nettype wire

// File: rtl/rout_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rout_sync_fifo
//  Description : Single-clock synchronous FIFO with registered full flag,
//                occupancy count and synchronous active-low reset.
//                DEPTH must be a power of two (>= 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module rout_sync_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    // Pushes are blocked by the registered full flag; pops of an empty FIFO are dropped
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    // Next occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and full-flag state; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule : rout_sync_fifo
`default_nettype wire

// File: rtl/column_end_readout.sv
`default_nettype none
// ============================================================================
//  Module      : column_end_readout
//  Description : Column-end receiver for the super-pixel arbiter chain.
//                Acknowledges arbiter words over shake_hands_next, tags them
//                with the column address and buffers them for the chip-level
//                valid/ready readout.
//  Options     : ROUT_HIT_CNT_EN - adds the 16-bit saturating hit_cnt output
//                cleared by a shutter rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module column_end_readout
    import pixel_rout_pkg::*;
#(
    parameter int COL_ADDR_W = COL_ADDR_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = ARB_DATA_W
) (
    input  logic                           clk_40MHz,
    input  logic                           rst_n,
    input  logic [COL_ADDR_W-1:0]          col_addr,
    input  logic [DATA_W-1:0]              arbiter_data,
    output logic                           shake_hands_next,
    input  logic                           shutter,
    output logic [COL_ADDR_W+DATA_W-2:0]   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           fifo_full
`ifdef ROUT_HIT_CNT_EN
    ,
    output logic [HIT_CNT_W-1:0]           hit_cnt
`endif
);

    localparam int TAG_W = COL_ADDR_W + DATA_W - 1;

    cap_state_e                  state_q, state_d;
    logic                        wr_en;
    logic                        fifo_empty;
    logic [TAG_W-1:0]            tagged_word;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

    // A word is taken only from IDLE, with space left and its hit flag set
    assign wr_en       = (state_q == IDLE) && !fifo_full && arbiter_data[DATA_W-1];
    assign tagged_word = {col_addr, arbiter_data[DATA_W-2:0]};

    // Capture FSM state register
    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture FSM next state: ACK always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_en) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture FSM output: acknowledge is held low throughout reset
    always_comb begin
        shake_hands_next = 1'b0;
        if (rst_n && (state_q == IDLE) && !fifo_full) shake_hands_next = 1'b1;
    end

    rout_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_40MHz),
        .rst_ni  (rst_n),
        .push_i  (wr_en),
        .data_i  (tagged_word),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    assign out_valid = !fifo_empty;

`ifdef ROUT_HIT_CNT_EN
    logic                 shutter_q;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // Hit counter next value: shutter rise clears, otherwise saturating increment
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (shutter && !shutter_q)
            hit_cnt_d = '0;
        else if (wr_en && (hit_cnt_q != {HIT_CNT_W{1'b1}}))
            hit_cnt_d = hit_cnt_q + 1'b1;
    end

    // Hit counter and shutter history registers
    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) begin
            shutter_q <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            shutter_q <= shutter;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    // Shutter is kept only for pin compatibility in this build
    logic shutter_unused;
    assign shutter_unused = shutter;
`endif

endmodule : column_end_readout
`default_nettype wire

// File: tb/tb_column_end_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_column_end_readout
//  Description : Scoreboard testbench for column_end_readout. A column model
//                presents arbiter words; every accepted word pushes its
//                expected tagged value into a queue that an independent
//                monitor compares against the readout port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_column_end_readout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  col_addr;
    logic [25:0] arbiter_data;
    logic        shake_hands_next;
    logic        shutter;
    logic [29:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        fifo_full;
`ifdef ROUT_HIT_CNT_EN
    logic [15:0] hit_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    logic [25:0] col_q [$];   // words the column still has to deliver
    logic [29:0] exp_q [$];   // expected readout words, in order
    logic [25:0] idle_word;

    always #5 clk = ~clk;

    column_end_readout dut (
        .clk_40MHz        (clk),
        .rst_n            (rst_n),
        .col_addr         (col_addr),
        .arbiter_data     (arbiter_data),
        .shake_hands_next (shake_hands_next),
        .shutter          (shutter),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .fifo_full        (fifo_full)
`ifdef ROUT_HIT_CNT_EN
        ,
        .hit_cnt          (hit_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock cycle of the column model: drive #1 after the edge and decide
    // from the handshake whether the upcoming edge takes the presented word.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            arbiter_data = (col_q.size() != 0) ? col_q[0] : idle_word;
            if (col_q.size() != 0 && rst_n && shake_hands_next && col_q[0][25]) begin
                exp_q.push_back({col_addr, col_q[0][24:0]});
                void'(col_q.pop_front());
                acc++;
            end
        end
    endtask

    // Monitor: mid-cycle, the head of the readout must match the scoreboard;
    // it is retired when the upcoming edge pops it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {2'b0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", {2'b0, out_data}, {2'b0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        col_addr     = 5'd3;
        idle_word    = 26'h2000001;
        arbiter_data = 26'h2000001;
        shutter      = 1'b0;
        out_ready    = 1'b0;

        // Reset: valid word present but nothing written, no handshake
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk("rst_shake", {31'b0, shake_hands_next}, 32'd0);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_full",  {31'b0, fifo_full}, 32'd0);
        end
        rst_n        = 1'b1;
        idle_word    = 26'h0;
        arbiter_data = 26'h0;
        run(1);
        chk("post_rst_shake", {31'b0, shake_hands_next}, 32'd1);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

        // Single word: {5'd3, 25'h0000ABC} = 30'h06000ABC
        out_ready = 1'b1;
        col_q.push_back(26'h2000ABC);
        run(1);
        chk("single_shake0", {31'b0, shake_hands_next}, 32'd1);
        chk("single_acc", acc, 32'd1);
        run(1);
        chk("single_shake1", {31'b0, shake_hands_next}, 32'd0);
        chk("single_valid", {31'b0, out_valid}, 32'd1);
        chk("single_data", {2'b0, out_data}, 32'h0600_0ABC);
        run(1);
        chk("single_shake2", {31'b0, shake_hands_next}, 32'd1);

        // Fill with readout stalled: 8 of 9 words taken
        out_ready = 1'b0;
        acc = 0;
        for (int w = 1; w <= 9; w++) col_q.push_back(26'h2000000 | 26'(w));
        run(20);
        chk("fill_acc",   acc, 32'd8);
        chk("fill_full",  {31'b0, fifo_full}, 32'd1);
        chk("fill_shake", {31'b0, shake_hands_next}, 32'd0);
        run(3);
        chk("fill_hold_shake", {31'b0, shake_hands_next}, 32'd0);
        chk("fill_hold_acc", acc, 32'd8);
        out_ready = 1'b1;
        run(1);
        out_ready = 1'b0;
        run(1);
        chk("word9_acc", acc, 32'd9);
        run(2);
        chk("refill_full", {31'b0, fifo_full}, 32'd1);
        out_ready = 1'b1;
        run(10);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_full",  {31'b0, fifo_full}, 32'd0);
        chk("drain_sb_empty", exp_q.size(), 32'd0);

        // Idle words never written, FSM stays in IDLE
        idle_word = 26'h0000ABC;
        for (int i = 0; i < 10; i++) begin
            run(1);
            chk("idle_shake", {31'b0, shake_hands_next}, 32'd1);
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
        end
        idle_word = 26'h0;

        // Reset during ACK with four words buffered
        out_ready = 1'b0;
        acc = 0;
        for (int w = 0; w < 4; w++) col_q.push_back(26'h2000100 | 26'(w));
        for (int i = 0; i < 12; i++) if (acc < 4) run(1);
        chk("mid_acc", acc, 32'd4);
        run(1);
        chk("mid_ack_shake", {31'b0, shake_hands_next}, 32'd0);
        chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        col_q.delete();
        run(2);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_full",  {31'b0, fifo_full}, 32'd0);
        chk("mid_rst_shake", {31'b0, shake_hands_next}, 32'd0);
        rst_n = 1'b1;
        run(1);
        chk("mid_rel_shake", {31'b0, shake_hands_next}, 32'd1);
        chk("mid_rel_valid", {31'b0, out_valid}, 32'd0);

`ifdef ROUT_HIT_CNT_EN
        // Hit counter: count, shutter clear over a write, saturation
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run(1);
        chk("cnt_rst", {16'b0, hit_cnt}, 32'd0);
        for (int w = 0; w < 5; w++) col_q.push_back(26'h2000200 | 26'(w));
        run(14);
        chk("cnt_five", {16'b0, hit_cnt}, 32'd5);
        col_q.push_back(26'h2000300);
        run(1);
        shutter = 1'b1;
        run(2);
        chk("cnt_shutter_clr", {16'b0, hit_cnt}, 32'd0);
        shutter = 1'b0;
        run(2);
        force dut.hit_cnt_q = 16'hFFFF;
        run(1);
        release dut.hit_cnt_q;
        col_q.push_back(26'h2000301);
        run(4);
        chk("cnt_saturate", {16'b0, hit_cnt}, 32'h0000_FFFF);
`endif

        out_ready = 1'b1;
        run(4);
        chk("final_sb_empty", exp_q.size(), 32'd0);
        chk("final_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_column_end_readout
`default_nettype wire
